// File: rtl/aes_block_loader.sv
// Assembles a 32-bit host word stream into an NK-word AES key and 128-bit blocks for the core.
// Optional build macro AES_LOADER_BYTE_SWAP_EN byte-reverses every accepted word (little-endian hosts).
module aes_block_loader #(
    parameter int NK    = 6,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    input  logic                s_key,
    input  logic [31:0]         s_data,
    output logic                s_ready,
    output logic [32*NK-1:0]    key_out,
    output logic [127:0]        blk_out,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic                key_loaded,
    output logic [CNT_W-1:0]    blk_count
);

    localparam int KCNT_W = $clog2(NK);

    generate
        if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
            $error("aes_block_loader: NK must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [KCNT_W-1:0]   kcnt_reg, kcnt_next;
    logic [1:0]          dcnt_reg, dcnt_next;
    logic                key_loaded_reg, key_loaded_next;
    logic [CNT_W-1:0]    blk_count_reg, blk_count_next;

    logic [31:0]         word_in;
    logic                accept;
    logic                key_acc;
    logic                data_acc;
    logic                handoff;

`ifdef AES_LOADER_BYTE_SWAP_EN
    assign word_in = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
    assign word_in = s_data;
`endif

    // Key words may only start between blocks; data needs a complete key.
    always_comb begin
        s_ready = 1'b0;
        if (!reset && state_reg == COLLECT) begin
            if (s_key) begin
                s_ready = (dcnt_reg == 2'd0);
            end else begin
                s_ready = key_loaded_reg;
            end
        end
    end

    assign accept   = s_valid && s_ready;
    assign key_acc  = accept && s_key;
    assign data_acc = accept && !s_key;
    assign handoff  = (state_reg == FULL) && blk_ready;

    always_comb begin
        state_next      = state_reg;
        kcnt_next       = kcnt_reg;
        dcnt_next       = dcnt_reg;
        key_loaded_next = key_loaded_reg;
        blk_count_next  = blk_count_reg;
        case (state_reg)
            COLLECT: begin
                if (key_acc) begin
                    if (kcnt_reg == KCNT_W'(0)) begin
                        key_loaded_next = 1'b0;
                    end
                    if (kcnt_reg == KCNT_W'(NK - 1)) begin
                        kcnt_next       = '0;
                        key_loaded_next = 1'b1;
                    end else begin
                        kcnt_next = kcnt_reg + KCNT_W'(1);
                    end
                end else if (data_acc) begin
                    if (dcnt_reg == 2'd3) begin
                        dcnt_next  = 2'd0;
                        state_next = FULL;
                    end else begin
                        dcnt_next = dcnt_reg + 2'd1;
                    end
                end
            end
            FULL: begin
                if (handoff) begin
                    state_next     = COLLECT;
                    blk_count_next = blk_count_reg + CNT_W'(1);
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= COLLECT;
            kcnt_reg       <= '0;
            dcnt_reg       <= '0;
            key_loaded_reg <= 1'b0;
            blk_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            kcnt_reg       <= kcnt_next;
            dcnt_reg       <= dcnt_next;
            key_loaded_reg <= key_loaded_next;
            blk_count_reg  <= blk_count_next;
        end
    end

    // One register per key slot; slot 0 lands in the most significant word.
    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (key_acc && kcnt_reg == KCNT_W'(gi)) begin
                    word_reg <= word_in;
                end
            end
            assign key_out[32*(NK-gi)-1 -: 32] = word_reg;
        end

        for (gi = 0; gi < 4; gi++) begin : g_blk
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (data_acc && dcnt_reg == 2'(gi)) begin
                    word_reg <= word_in;
                end
            end
            assign blk_out[32*(4-gi)-1 -: 32] = word_reg;
        end
    endgenerate

    assign blk_valid  = (state_reg == FULL);
    assign key_loaded = key_loaded_reg;
    assign blk_count  = blk_count_reg;

endmodule

// File: tb/tb_aes_block_loader.sv
// Randomized self-checking bench for aes_block_loader against a queue-based behavioural model.
module tb_aes_block_loader;

    localparam int NK    = 6;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_key = 1'b0;
    logic [31:0]         s_data = '0;
    logic                s_ready;
    logic [32*NK-1:0]    key_out;
    logic [127:0]        blk_out;
    logic                blk_valid;
    logic                blk_ready = 1'b0;
    logic                key_loaded;
    logic [CNT_W-1:0]    blk_count;

    aes_block_loader #(.NK(NK), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_key      (s_key),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .key_out    (key_out),
        .blk_out    (blk_out),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .key_loaded (key_loaded),
        .blk_count  (blk_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: stored key, partial key/block progress, pending block, handoff count.
    logic [31:0]  m_key [NK];
    int           m_kidx;
    bit           m_loaded;
    logic [31:0]  m_part [$];
    logic [31:0]  m_blk [4];
    bit           m_full;
    int unsigned  m_count;

    localparam logic [191:0] KEY_LIT = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] BLK_LIT = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Word as the host sends it, and word as the loader must store it.
    function automatic logic [31:0] host_word(input logic [31:0] w);
`ifdef AES_LOADER_BYTE_SWAP_EN
        return bswap(w);
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] stored_word(input logic [31:0] w);
`ifdef AES_LOADER_BYTE_SWAP_EN
        return bswap(w);
`else
        return w;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NK; i++) m_key[i] = '0;
        m_kidx   = 0;
        m_loaded = 0;
        m_part.delete();
        m_full   = 0;
        m_count  = 0;
    endtask

    // One clock: drive at negedge, compare before the edge, advance the model at the edge.
    task automatic cycle(input bit rst, input bit v, input bit k, input logic [31:0] d, input bit rdy);
        bit                exp_ready;
        logic [32*NK-1:0]  kvec;
        logic [127:0]      bvec;
        @(negedge clk);
        reset = rst; s_valid = v; s_key = k; s_data = d; blk_ready = rdy;
        #1;
        exp_ready = !rst && !m_full && (k ? (m_part.size() == 0) : m_loaded);
        for (int i = 0; i < NK; i++) kvec[32*(NK-i)-1 -: 32] = m_key[i];
        for (int i = 0; i < 4; i++) bvec[32*(4-i)-1 -: 32] = m_blk[i];
        check("s_ready", s_ready, exp_ready);
        check("blk_valid", blk_valid, m_full);
        check("key_loaded", key_loaded, m_loaded);
        check("blk_count", blk_count, m_count[CNT_W-1:0]);
        check("key_out", key_out, kvec);
        if (m_full) check("blk_out", blk_out, bvec);
        @(posedge clk);
        if (rst) begin
            model_reset();
            $display("reset");
        end else if (m_full && rdy) begin
            m_full = 0;
            m_count++;
            $display("handoff %0d blk=%h", m_count, bvec);
        end else if (v && exp_ready) begin
            if (k) begin
                if (m_kidx == 0) m_loaded = 0;
                m_key[m_kidx] = stored_word(d);
                m_kidx++;
                if (m_kidx == NK) begin
                    m_kidx   = 0;
                    m_loaded = 1;
                end
            end else begin
                m_part.push_back(stored_word(d));
                if (m_part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_blk[i] = m_part[i];
                    m_part.delete();
                    m_full = 1;
                end
            end
        end
    endtask

    logic [31:0] key_w [NK] = '{32'h00010203, 32'h04050607, 32'h08090a0b,
                               32'h0c0d0e0f, 32'h10111213, 32'h14151617};
    logic [31:0] dat_w [4]  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

    initial begin
        model_reset();
        cycle(1, 0, 0, '0, 0);
        cycle(1, 1, 0, 32'h1, 1);

        // Data before any key must be refused.
        repeat (3) cycle(0, 1, 0, host_word(32'hdeadbeef), 0);

        for (int i = 0; i < NK; i++) cycle(0, 1, 1, host_word(key_w[i]), 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, host_word(dat_w[i]), 0);
        repeat (3) cycle(0, 1, 0, host_word(32'h12345678), 0);
        #1;
        check("key_literal", key_out, KEY_LIT);
        check("blk_literal", blk_out, BLK_LIT);
        check("blk_held", blk_valid, 1'b1);

        // Handoff with a word pending, then a back-to-back second block.
        cycle(0, 1, 0, host_word(32'ha0a1a2a3), 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, host_word(32'ha0a1a2a3 + i), 0);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);
        #1;
        check("count_two", blk_count, CNT_W'(2));
        check("key_kept", key_out, KEY_LIT);

        // Key word offered mid-block waits for the handoff.
        cycle(0, 1, 0, host_word(32'h11111111), 0);
        cycle(0, 1, 0, host_word(32'h22222222), 0);
        repeat (2) cycle(0, 1, 1, host_word(32'hcafef00d), 0);
        cycle(0, 1, 0, host_word(32'h33333333), 0);
        cycle(0, 1, 0, host_word(32'h44444444), 0);
        cycle(0, 1, 1, host_word(32'hcafef00d), 1);
        cycle(0, 1, 1, host_word(32'hcafef00d), 0);

        // Finish that key, fill a block, reset while FULL, then reload.
        for (int i = 1; i < NK; i++) cycle(0, 1, 1, host_word(32'h5a5a0000 + i), 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, host_word(32'h77770000 + i), 0);
        cycle(1, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);
        for (int i = 0; i < NK; i++) cycle(0, 1, 1, host_word(key_w[i]), 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, host_word(dat_w[i]), 0);
        cycle(0, 0, 0, '0, 1);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom % 250) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                  $urandom, ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the parameterised AES core.
- Accepts a 32-bit word stream from the host and assembles a Nk-word cipher key and 4-word (128-bit) data blocks.
- Presents each assembled key/block pair on a valid/ready interface that drives the core's key and in inputs.
- Decouples the host word rate from core block timing: one block of buffering and a reload-safe key register.

Parameters:
- NK, 6, key length in 32-bit words; legal values 4/6/8 (AES-128/192/256); other values are a synthesis-time error.
- CNT_W, 16, width of the emitted-block counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  host word valid.
- s_key  in  1  sideband: 1 = word is a key word, 0 = data word; qualified by s_valid.
- s_data  in  32  host word; first word of a key/block is most significant.
- s_ready  out  1  loader accepts the word this cycle.
- key_out  out  32*NK  assembled key to core key input; word 0 at bits [32*NK-1 -: 32].
- blk_out  out  128  assembled block to core in; word 0 at [127:96].
- blk_valid  out  1  key_out/blk_out hold a complete pair.
- blk_ready  in  1  downstream (core launch) accepts the pair.
- key_loaded  out  1  complete key present.
- blk_count  out  CNT_W  number of blocks handed off, wraps modulo 2^CNT_W.

Behaviour:
- Reset (sync, high): all state cleared; s_ready=0 during reset cycle; blk_valid=0, key_loaded=0, blk_count=0, key_out=0, blk_out=0, word counters kcnt=dcnt=0, FSM=COLLECT.
- Transfer on the host side: a word moves when s_valid && s_ready at a rising edge. On the output side: blk_valid && blk_ready.
- FSM states:
  - COLLECT: accepting words.
  - FULL: blk_valid=1, waiting for handoff.
- s_ready (combinational from registers and s_key):
  - key word: state==COLLECT && dcnt==0.
  - data word: state==COLLECT && key_loaded.
  - In FULL, s_ready=0.
- Key word accepted: written to key slot kcnt. If kcnt==0, key_loaded clears on the same edge (new key load in progress). kcnt increments. On slot NK-1: kcnt wraps to 0 and key_loaded sets.
- Key words never interleave with a partial block (dcnt!=0 blocks them). A key load may be abandoned mid-way by sending data: not possible because key_loaded=0 rejects data. The host must complete the key.
- Data word accepted: written to slot dcnt, dcnt increments. On slot 3: dcnt wraps to 0 and the FSM goes to FULL.
  - blk_valid is registered, high starting the cycle after the edge that accepted word 3.
  - Latency: 4th data word to blk_valid = 1 cycle.
- FULL: key_out/blk_out held stable while blk_valid=1, independent of s_valid.
  - On the handoff edge: FSM goes to COLLECT, blk_valid goes to 0, blk_count increments (2^CNT_W-1 wraps to 0).
  - s_ready stays 0 in the handoff cycle; the earliest next word is accepted the following cycle.
  - Sustained throughput: 4 data words + 1 handoff = 5 cycles per block minimum.
- Key persists across blocks: multiple blocks reuse the key until a new key word with kcnt==0 arrives.
- Data registers are not cleared on handoff; contents are only defined while blk_valid=1.
- blk_ready while blk_valid=0 is ignored.
- Reset during FULL or mid-load discards all partial/pending words; no handoff and no counter increment.

Optional Feature:
- Macro: AES_LOADER_BYTE_SWAP_EN.
- Defined: every accepted s_data word (key and data) is byte-reversed before storage ({b0,b1,b2,b3}), for little-endian hosts.
- Undefined: words are stored exactly as received.
- Counters, handshake and latency are identical in both builds.

Test Plan:
- Reset, NK=6, no byte swap; key words 00010203,04050607,08090a0b,0c0d0e0f,10111213,14151617 then data 00112233,44556677,8899aabb,ccddeeff, blk_ready=0 -> key_loaded=1 after 6th key; blk_valid=1 one cycle after 4th data; key_out=000102030405060708090a0b0c0d0e0f1011121314151617; blk_out=00112233445566778899aabbccddeeff; s_ready=0 while held.
- Data word offered before any key (key_loaded=0) -> s_ready=0, no dcnt change, blk_valid stays 0.
- From the first test, assert blk_ready=1 for one cycle, then send 4 more data words back to back -> blk_count=1 after handoff; s_ready=0 on the handoff cycle; second block emitted; blk_count=2 after second handoff; key_out unchanged.
- Key word offered after 2 data words (dcnt=2) -> s_ready=0 until the block completes and hands off.
- Assert reset while FULL -> next cycle blk_valid=0, key_loaded=0, blk_count=0; a fresh key + block load completes normally.
- AES_LOADER_BYTE_SWAP_EN defined, first data word 33221100 (key as in the first test, each word reversed) -> blk_out[127:96]=00112233; key_out matches the first test.
